// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one RV32I ALU between two requesters,
// with a one-entry registered result buffer tagged by requester ID.

`ifndef ALU_OP_ADD
`define ALU_OP_ADD  4'd0
`define ALU_OP_SUB  4'd1
`define ALU_OP_SLL  4'd2
`define ALU_OP_SLT  4'd3
`define ALU_OP_SLTU 4'd4
`define ALU_OP_XOR  4'd5
`define ALU_OP_SRL  4'd6
`define ALU_OP_SRA  4'd7
`define ALU_OP_OR   4'd8
`define ALU_OP_AND  4'd9
`endif

// Purely combinational RV32I ALU; undefined opcodes produce zero.
module alu_arbiter_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] s1,
    input  logic [DATA_WIDTH-1:0] s2,
    output logic [DATA_WIDTH-1:0] result
);
    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    assign shamt       = s2[4:0];
    assign lt_signed   = $signed(s1) < $signed(s2);
    assign lt_unsigned = s1 < s2;

    // Opcode decode into the selected arithmetic/logic result.
    always_comb begin
        result = '0;
        case (op)
            `ALU_OP_ADD:  result = s1 + s2;
            `ALU_OP_SUB:  result = s1 - s2;
            `ALU_OP_SLL:  result = s1 << shamt;
            `ALU_OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
            `ALU_OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, lt_unsigned};
            `ALU_OP_XOR:  result = s1 ^ s2;
            `ALU_OP_SRL:  result = s1 >> shamt;
            `ALU_OP_SRA:  result = DATA_WIDTH'($signed(s1) >>> shamt);
            `ALU_OP_OR:   result = s1 | s2;
            `ALU_OP_AND:  result = s1 & s2;
            default:      result = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [DATA_WIDTH-1:0] req0_s1,
    input  logic [DATA_WIDTH-1:0] req0_s2,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [OP_WIDTH-1:0]   req1_op,
    input  logic [DATA_WIDTH-1:0] req1_s1,
    input  logic [DATA_WIDTH-1:0] req1_s2,
    output logic                  req1_ready,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_ready
);
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  prio_q, prio_d;

    logic                  slot_free;
    logic                  grant0, grant1;
    logic                  accept;
    logic [OP_WIDTH-1:0]   alu_op;
    logic [DATA_WIDTH-1:0] alu_s1, alu_s2, alu_result;

    // Grant and handshake: lone valid wins, ties go to the port named by prio.
    always_comb begin
        slot_free  = !rsp_valid_q || rsp_ready;
        grant1     = req1_valid && (!req0_valid || prio_q);
        grant0     = req0_valid && !grant1;
        req0_ready = slot_free && grant0;
        req1_ready = slot_free && grant1;
        accept     = req0_ready || req1_ready;
    end

    // Operand mux feeding the shared ALU from the granted port.
    always_comb begin
        alu_op = grant1 ? req1_op : req0_op;
        alu_s1 = grant1 ? req1_s1 : req0_s1;
        alu_s2 = grant1 ? req1_s2 : req0_s2;
    end

    alu_arbiter_alu #(
        .DATA_WIDTH(DATA_WIDTH),
        .OP_WIDTH  (OP_WIDTH)
    ) u_alu (
        .op    (alu_op),
        .s1    (alu_s1),
        .s2    (alu_s2),
        .result(alu_result)
    );

    // Buffer/priority next state: accept reloads (even while draining), a lone drain empties.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        prio_d      = prio_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant1;
            rsp_data_d  = alu_result;
            prio_d      = !grant1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any buffered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            prio_q      <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            prio_q      <= prio_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run against a spec-level reference model.
module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                           OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_OR = 4'd8, OP_AND = 4'd9, OP_BAD = 4'd13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_s1 = '0, req0_s2 = '0, req1_s1 = '0, req1_s2 = '0;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_op   (req0_op),
        .req0_s1   (req0_s1),
        .req0_s2   (req0_s2),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_op   (req1_op),
        .req1_s1   (req1_s1),
        .req1_s2   (req1_s2),
        .req1_ready(req1_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic [3:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference ALU written from the instruction-set rules.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a + (~b) + 32'd1;
            OP_SLL:  return a << sh;
            OP_SLT:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_XOR:  return a ^ b;
            OP_SRL:  return a >> sh;
            OP_SRA:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_req(input int k, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (k == 0) begin
            req0_valid = v; req0_op = op; req0_s1 = a; req0_s2 = b;
        end else begin
            req1_valid = v; req1_op = op; req1_s1 = a; req1_s2 = b;
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, OP_ADD, 0, 0);
        set_req(1, 1'b0, OP_ADD, 0, 0);
        rsp_ready = 1'b0;
        edge_step();
        edge_step();
        rst_n = 1'b1;
        #1;
    endtask

    // Reference model state
    logic        m_valid, m_id, m_last;
    logic [31:0] m_data;
    logic        p0_pend, p1_pend;

    initial begin
        logic exp_r0, exp_r1, win, slot;

        vecs[0]  = '{1'b0, OP_ADD,  32'd5,          32'd7,          32'h0000_000C};
        vecs[1]  = '{1'b0, OP_ADD,  32'hFFFF_FFFF,  32'd1,          32'h0000_0000};
        vecs[2]  = '{1'b1, OP_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE};
        vecs[3]  = '{1'b1, OP_SRA,  32'h8000_0000,  32'h0000_0024,  32'hF800_0000};
        vecs[4]  = '{1'b0, OP_SLL,  32'd1,          32'h0000_0021,  32'h0000_0002};
        vecs[5]  = '{1'b1, OP_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000};
        vecs[6]  = '{1'b0, OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'h0000_0001};
        vecs[7]  = '{1'b0, OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000};
        vecs[8]  = '{1'b1, OP_SLT,  32'd1,          32'hFFFF_FFFF,  32'h0000_0000};
        vecs[9]  = '{1'b0, OP_XOR,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0};
        vecs[10] = '{1'b1, OP_OR,   32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0};
        vecs[11] = '{1'b0, OP_AND,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000};
        vecs[12] = '{1'b0, OP_BAD,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};
        vecs[13] = '{1'b1, OP_SRA,  32'h4000_0000,  32'd1,          32'h2000_0000};

        // Reset state
        do_reset();
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_ready0", {31'd0, req0_ready}, 32'd0);

        // Directed vector table, one requester at a time
        rsp_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            set_req(int'(vecs[i].port), 1'b1, vecs[i].op, vecs[i].s1, vecs[i].s2);
            set_req(int'(!vecs[i].port), 1'b0, OP_ADD, 0, 0);
            #1;
            check($sformatf("vec%0d_ready", i),
                  {30'd0, req1_ready, req0_ready}, vecs[i].port ? 32'd2 : 32'd1);
            edge_step();
            set_req(int'(vecs[i].port), 1'b0, OP_ADD, 0, 0);
            check($sformatf("vec%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("vec%0d_id", i), {31'd0, rsp_id}, {31'd0, vecs[i].port});
            check($sformatf("vec%0d_data", i), rsp_data, vecs[i].exp);
        end
        #1;
        edge_step();
        check("drain_valid", {31'd0, rsp_valid}, 32'd0);

        // Both ports valid, alternating grants
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, OP_SLT,  32'hFFFF_FFFF, 32'd1);
        set_req(1, 1'b1, OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("alt%0d_grant", i), {30'd0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            edge_step();
            check($sformatf("alt%0d_id", i), {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("alt%0d_data", i), rsp_data, (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Backpressure: one accept, then stall with both valid
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
        #1;
        edge_step();
        set_req(0, 1'b1, OP_XOR, 32'hAAAA_0000, 32'h0000_5555);
        set_req(1, 1'b1, OP_SUB, 32'd10, 32'd4);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d_readies", i), {30'd0, req1_ready, req0_ready}, 32'd0);
            edge_step();
            check($sformatf("bp%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("bp%0d_data", i), rsp_data, 32'd3);
            check($sformatf("bp%0d_id", i), {31'd0, rsp_id}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
        edge_step();
        check("bp_reload_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_reload_id", {31'd0, rsp_id}, 32'd1);
        check("bp_reload_data", rsp_data, 32'd6);

        // Reset mid-operation: buffer full and stalled, reset between edges
        set_req(1, 1'b0, OP_ADD, 0, 0);
        rsp_ready = 1'b0;
        #1;
        edge_step();
        check("mid_full", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("async_rst_data", rsp_data, 32'd0);
        check("async_rst_id", {31'd0, rsp_id}, 32'd0);
        edge_step();
        rst_n = 1'b1;
        set_req(0, 1'b1, OP_ADD, 32'd100, 32'd1);
        set_req(1, 1'b1, OP_ADD, 32'd200, 32'd1);
        #1;
        check("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        edge_step();
        check("post_rst_data", rsp_data, 32'd101);

        // Randomized run against the reference model
        do_reset();
        m_valid = 1'b0; m_id = 1'b0; m_data = '0; m_last = 1'b1;
        p0_pend = 1'b0; p1_pend = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!p0_pend && ($urandom_range(0, 3) != 0)) begin
                p0_pend = 1'b1;
                set_req(0, 1'b1, 4'($urandom_range(0, 15)),
                        ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
                        ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom);
            end else if (!p0_pend) begin
                set_req(0, 1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
            end
            if (!p1_pend && ($urandom_range(0, 2) != 0)) begin
                p1_pend = 1'b1;
                set_req(1, 1'b1, 4'($urandom_range(0, 15)), $urandom,
                        ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 63)) : $urandom);
            end else if (!p1_pend) begin
                set_req(1, 1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            slot = !m_valid || rsp_ready;
            if (req0_valid && req1_valid) win = !m_last;
            else win = req1_valid;
            exp_r0 = slot && req0_valid && !win;
            exp_r1 = slot && req1_valid && win;
            check("rand_readies", {30'd0, req1_ready, req0_ready}, {30'd0, exp_r1, exp_r0});
            edge_step();
            if (exp_r0 || exp_r1) begin
                m_valid = 1'b1;
                m_id    = win;
                m_last  = win;
                m_data  = win ? ref_alu(req1_op, req1_s1, req1_s2) : ref_alu(req0_op, req0_s1, req0_s2);
                if (win) p1_pend = 1'b0; else p0_pend = 1'b0;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
            if (!p0_pend) req0_valid = 1'b0;
            if (!p1_pend) req1_valid = 1'b0;
            check("rand_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
            check("rand_rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
            check("rand_rsp_data", rsp_data, m_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
